// File: rtl/fetch_queue_unit.sv
// Instruction fetch front end: pipelined memory reads with bounded outstanding requests,
// a {pc, inst} queue towards decode, and single-cycle redirect that drops stale responses.

module fetch_queue_unit_chk #(
   parameter int unsigned OCntW = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             mem_rvalid_i,
   input  logic [OCntW-1:0] inflight_i
);
   // A response with nothing outstanding is a memory protocol violation
   a_rsp_has_request: assert property (@(posedge clk_i) disable iff (rst_i)
      !(mem_rvalid_i && (inflight_i == {OCntW{1'b0}})))
      else $error("fetch_queue_unit: memory response with no request outstanding");
endmodule

module fetch_queue_unit #(
   parameter logic [31:0] ResetPc        = 32'h0000_0000,
   parameter int unsigned QueueDepthLog2 = 2,
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        mem_ready_i,
   output logic        mem_valid_o,
   output logic [31:0] mem_addr_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_rvalid_i,
   input  logic        redirect_valid_i,
   input  logic [31:0] redirect_pc_i,
   output logic        inst_valid_o,
   input  logic        inst_ready_i,
   output logic [31:0] inst_pc_o,
   output logic [31:0] inst_data_o
);
   localparam int unsigned Depth = 2 ** QueueDepthLog2;
   localparam int unsigned QCntW = QueueDepthLog2 + 1;
   localparam int unsigned QPtrW = (QueueDepthLog2 > 0) ? QueueDepthLog2 : 1;
   localparam int unsigned OCntW = $clog2(MaxOutstanding + 1);
   localparam int unsigned TPtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam int unsigned SumW  = QCntW + 1;

   localparam logic [OCntW-1:0] OZero  = OCntW'(32'd0);
   localparam logic [OCntW-1:0] OOne   = OCntW'(32'd1);
   localparam logic [OCntW-1:0] OMax   = OCntW'(MaxOutstanding);
   localparam logic [QCntW-1:0] QZero  = QCntW'(32'd0);
   localparam logic [QCntW-1:0] QOne   = QCntW'(32'd1);
   localparam logic [QPtrW-1:0] QPZero = QPtrW'(32'd0);
   localparam logic [QPtrW-1:0] QPLast = QPtrW'(Depth - 32'd1);
   localparam logic [TPtrW-1:0] TPZero = TPtrW'(32'd0);
   localparam logic [TPtrW-1:0] TPLast = TPtrW'(MaxOutstanding - 32'd1);
   localparam logic [SumW-1:0]  SDepth = SumW'(Depth);

   function automatic logic [QPtrW-1:0] qptr_inc(input logic [QPtrW-1:0] p);
      if (p == QPLast) begin
         return QPZero;
      end else begin
         return p + QPtrW'(32'd1);
      end
   endfunction

   function automatic logic [TPtrW-1:0] tptr_inc(input logic [TPtrW-1:0] p);
      if (p == TPLast) begin
         return TPZero;
      end else begin
         return p + TPtrW'(32'd1);
      end
   endfunction

   logic [31:0]      pc_r;
   logic [OCntW-1:0] inflight_r;
   logic [OCntW-1:0] drop_r;
   logic [QCntW-1:0] count_r;
   logic [QPtrW-1:0] q_rd_r;
   logic [QPtrW-1:0] q_wr_r;
   logic [31:0]      q_pc_r   [Depth];
   logic [31:0]      q_data_r [Depth];
   logic [TPtrW-1:0] t_rd_r;
   logic [TPtrW-1:0] t_wr_r;
   logic [31:0]      tag_r    [2**TPtrW];

   logic [31:0]      target_s;
   logic [OCntW-1:0] live_s;
   logic [SumW-1:0]  credit_s;
   logic             accept_s;
   logic             rsp_s;
   logic             drop_rsp_s;
   logic             keep_rsp_s;
   logic             pop_s;
   logic             redirect_lsb_unused_s;

   assign redirect_lsb_unused_s = ^redirect_pc_i[1:0];

   // Request address, issue credit and per-cycle event decode
   always_comb begin
      target_s = {redirect_pc_i[31:2], 2'b00};
      live_s   = inflight_r - drop_r;
      // A redirect empties the queue and orphans every older request, so neither holds credit
      if (redirect_valid_i) begin
         mem_addr_o = target_s;
         credit_s   = {SumW{1'b0}};
      end else begin
         mem_addr_o = pc_r;
         credit_s   = SumW'(live_s) + SumW'(count_r);
      end
      mem_valid_o  = !rst_i && (inflight_r < OMax) && (credit_s < SDepth);
      accept_s     = mem_valid_o && mem_ready_i;
      rsp_s        = mem_rvalid_i && (inflight_r != OZero);
      drop_rsp_s   = rsp_s && ((drop_r != OZero) || redirect_valid_i);
      keep_rsp_s   = rsp_s && !drop_rsp_s;
      inst_valid_o = (count_r != QZero);
      pop_s        = inst_valid_o && inst_ready_i && !redirect_valid_i;
      inst_pc_o    = q_pc_r[q_rd_r];
      inst_data_o  = q_data_r[q_rd_r];
   end

   // Fetch pc, outstanding-request and discard counters
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pc_r       <= ResetPc;
         inflight_r <= OZero;
         drop_r     <= OZero;
      end else begin
         if (accept_s) begin
            pc_r <= mem_addr_o + 32'd4;
         end else if (redirect_valid_i) begin
            pc_r <= target_s;
         end else begin
            pc_r <= pc_r;
         end

         case ({accept_s, rsp_s})
            2'b10:   inflight_r <= inflight_r + OOne;
            2'b01:   inflight_r <= inflight_r - OOne;
            default: inflight_r <= inflight_r;
         endcase

         if (redirect_valid_i) begin
            drop_r <= rsp_s ? (inflight_r - OOne) : inflight_r;
         end else if (rsp_s && (drop_r != OZero)) begin
            drop_r <= drop_r - OOne;
         end else begin
            drop_r <= drop_r;
         end
      end
   end

   // pc tags of live requests, popped in order as their responses are kept
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         t_rd_r <= TPZero;
         t_wr_r <= TPZero;
         for (int i = 0; i < (2 ** int'(TPtrW)); i++) begin
            tag_r[i] <= 32'h0000_0000;
         end
      end else if (redirect_valid_i) begin
         t_rd_r <= TPZero;
         if (accept_s) begin
            tag_r[TPZero] <= mem_addr_o;
            t_wr_r        <= tptr_inc(TPZero);
         end else begin
            t_wr_r <= TPZero;
         end
      end else begin
         if (accept_s) begin
            tag_r[t_wr_r] <= mem_addr_o;
            t_wr_r        <= tptr_inc(t_wr_r);
         end else begin
            t_wr_r <= t_wr_r;
         end
         if (keep_rsp_s) begin
            t_rd_r <= tptr_inc(t_rd_r);
         end else begin
            t_rd_r <= t_rd_r;
         end
      end
   end

   // Instruction queue storage and occupancy towards decode
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_r <= QZero;
         q_rd_r  <= QPZero;
         q_wr_r  <= QPZero;
         for (int i = 0; i < int'(Depth); i++) begin
            q_pc_r[i]   <= 32'h0000_0000;
            q_data_r[i] <= 32'h0000_0000;
         end
      end else if (redirect_valid_i) begin
         count_r <= QZero;
         q_rd_r  <= QPZero;
         q_wr_r  <= QPZero;
      end else begin
         if (keep_rsp_s) begin
            q_pc_r[q_wr_r]   <= tag_r[t_rd_r];
            q_data_r[q_wr_r] <= mem_rdata_i;
            q_wr_r           <= qptr_inc(q_wr_r);
         end else begin
            q_wr_r <= q_wr_r;
         end
         if (pop_s) begin
            q_rd_r <= qptr_inc(q_rd_r);
         end else begin
            q_rd_r <= q_rd_r;
         end
         case ({keep_rsp_s, pop_s})
            2'b10:   count_r <= count_r + QOne;
            2'b01:   count_r <= count_r - QOne;
            default: count_r <= count_r;
         endcase
      end
   end

   fetch_queue_unit_chk #(
      .OCntW(OCntW)
   ) u_chk (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .mem_rvalid_i (mem_rvalid_i),
      .inflight_i   (inflight_r)
   );
endmodule
